count_month: RTL



---
 rtl/clock_pkg.sv | 23 ++
 rtl/month_class_decode.sv | 35 +++
 rtl/count_month.sv | 105 ++++++++++
 3 files changed

// File: rtl/clock_pkg.sv
// Shared definitions for the calendar counters (day, month, year).
// Holds the legal month range, the 31/30-day month lists and the BCD
// digit type used by every counter that shows a two-digit field.
package clock_pkg;

  localparam logic [7:0] MONTH_MIN = 8'd1;
  localparam logic [7:0] MONTH_MAX = 8'd12;
  localparam logic [7:0] FEB       = 8'd2;

  // Bit n is set when month n has 31 days (bit 0 is unused).
  // Months 01,03,05,07,08,10,12.
  localparam logic [15:0] MONTH31_MASK = 16'b0001_0101_1010_1010;
  // Bit n is set when month n has 30 days. Months 04,06,09,11.
  localparam logic [15:0] MONTH30_MASK = 16'b0000_1010_0101_0000;

  typedef logic [3:0] bcd_digit_t;

  // Binary value of a two-digit BCD field.
  function automatic logic [7:0] bcd_to_bin(input bcd_digit_t ten, input bcd_digit_t unit);
    return ({4'd0, ten} * 8'd10) + {4'd0, unit};
  endfunction

endpackage

// File: rtl/month_class_decode.sv
// Combinational month classifier: {ten,unit} -> 31-day / 30-day / February
// flags plus a legality flag. The three class flags are one-hot for a legal
// month and all clear for anything outside 01..12 or with a unit digit > 9.
module month_class_decode
  import clock_pkg::*;
#(
  parameter int UNIT_W = 4,
  parameter int TEN_W  = 1
) (
  input  logic [UNIT_W-1:0] unit,
  input  logic [TEN_W-1:0]  ten,
  output logic              is_31,
  output logic              is_30,
  output logic              is_feb,
  output logic              legal
);

  logic [7:0] month_num;

  // Classify the month value; flags stay clear unless the value is legal.
  // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    month_num = bcd_to_bin(bcd_digit_t'(ten), bcd_digit_t'(unit));
    legal     = (unit <= UNIT_W'(9)) && (month_num >= MONTH_MIN) && (month_num <= MONTH_MAX);
    is_31     = 1'b0;
    is_30     = 1'b0;
    is_feb    = 1'b0;
    if (legal) begin
      is_31  = MONTH31_MASK[month_num[3:0]];
      is_30  = MONTH30_MASK[month_num[3:0]];
      is_feb = (month_num == FEB);
    end
  end

endmodule

// File: rtl/count_month.sv
// BCD month counter 01..12, fed by the day counter's end-of-month pulse.
// Steps up/down in set mode, feeds the month-length flags back to the day
// counter and emits a one-cycle year carry on the 12 -> 01 run-mode wrap.
// Optional build macro MONTH_LOAD_EN adds a parallel load port.
module count_month
  import clock_pkg::*;
#(
  parameter int MAX_DISPLAY_UNIT = 4,
  parameter int MAX_DISPLAY_TEN  = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        en_m,
  input  logic                        up,
  input  logic                        down,
`ifdef MONTH_LOAD_EN
  input  logic                        load,
  input  logic [MAX_DISPLAY_UNIT-1:0] load_unit,
  input  logic [MAX_DISPLAY_TEN-1:0]  load_ten,
`endif
  output logic [MAX_DISPLAY_UNIT-1:0] month_unit,
  output logic [MAX_DISPLAY_TEN-1:0]  month_ten,
  output logic                        TO,
  output logic                        T,
  output logic                        TN,
  output logic                        pulse_m
);

  logic [MAX_DISPLAY_UNIT-1:0] unit_q;
  logic [MAX_DISPLAY_TEN-1:0]  ten_q;
  logic                        legal;
  logic                        is_dec;
  logic                        is_jan;
  logic                        load_req;
  logic                        step_up;
  logic                        step_down;

  month_class_decode #(
    .UNIT_W (MAX_DISPLAY_UNIT),
    .TEN_W  (MAX_DISPLAY_TEN)
  ) u_decode (
    .unit   (unit_q),
    .ten    (ten_q),
    .is_31  (TO),
    .is_30  (T),
    .is_feb (TN),
    .legal  (legal)
  );

`ifdef MONTH_LOAD_EN
  assign load_req = load;
`else
  assign load_req = 1'b0;
`endif

  assign is_dec    = (ten_q == MAX_DISPLAY_TEN'(1)) && (unit_q == MAX_DISPLAY_UNIT'(2));
  assign is_jan    = (ten_q == MAX_DISPLAY_TEN'(0)) && (unit_q == MAX_DISPLAY_UNIT'(1));
  assign step_up   = en_m || (up && !down);
  assign step_down = !en_m && down && !up;

  // Year carry is only raised by a run-mode advance out of December.
  assign pulse_m    = en_m && is_dec && !load_req;
  assign month_unit = unit_q;
  assign month_ten  = ten_q;

  // Month register: recovery > load > advance/up > down > hold.
  // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ten_q  <= '0;
      unit_q <= MAX_DISPLAY_UNIT'(1);
    end else if (!legal) begin
      ten_q  <= '0;
      unit_q <= MAX_DISPLAY_UNIT'(1);
    end
`ifdef MONTH_LOAD_EN
    else if (load) begin
      ten_q  <= load_ten;
      unit_q <= load_unit;
    end
`endif
    else if (step_up) begin
      if (is_dec) begin
        ten_q  <= '0;
        unit_q <= MAX_DISPLAY_UNIT'(1);
      end else if (unit_q == MAX_DISPLAY_UNIT'(9)) begin
        ten_q  <= ten_q + MAX_DISPLAY_TEN'(1);
        unit_q <= '0;
      end else begin
        unit_q <= unit_q + MAX_DISPLAY_UNIT'(1);
      end
    end else if (step_down) begin
      if (is_jan) begin
        ten_q  <= MAX_DISPLAY_TEN'(1);
        unit_q <= MAX_DISPLAY_UNIT'(2);
      end else if (unit_q == '0) begin
        ten_q  <= ten_q - MAX_DISPLAY_TEN'(1);
        unit_q <= MAX_DISPLAY_UNIT'(9);
      end else begin
        unit_q <= unit_q - MAX_DISPLAY_UNIT'(1);
      end
    end
  end

endmodule
